// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Optional feature macro used by the arbiter: DMEM_ADDR_CHECK_EN.
package dmem_pkg;

    localparam int DMEM_ADDR_W      = 32;
    localparam int DMEM_DATA_W      = 32;
    localparam int DMEM_DEPTH_WORDS = 16384;

    // One access in flight at a time: wait for a winner, drive memory, report back
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_t;

    // Request fields latched on the accept edge. "byte" is a reserved word,
    // so the byte-access flag is called byte_en here.
    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic                   we;
        logic                   byte_en;
    } dmem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. Purely combinational; the caller owns the
// last-grant pointer (last = 1 means port 1 won the previous access).
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie the port that did not win last time goes
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory (memoriaDatos) between the core LSU
// (port 0) and the loader/debug DMA (port 1). One access every three cycles:
// accept in IDLE, drive the memory for one ACCESS cycle, pulse the response in RESP.
// Optional feature: define DMEM_ADDR_CHECK_EN to reject word addresses at or
// beyond DEPTH_WORDS with an error response and no memory side effect.
// The request struct comes from dmem_pkg, so ADDR_W/DATA_W are expected to
// stay at the package widths.
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_we,
    input  logic              p0_byte,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_we,
    input  logic              p1_byte,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_MW,
    output logic              mem_SB,
    output logic              mem_loadByte,
    input  logic [DATA_W-1:0] mem_RD,

    output logic              busy
);

    dmem_state_t       state_q, state_d;
    dmem_req_t         req_q, sel_req;
    logic              gid_q;
    logic              last_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        grant;
    logic              accept;
    logic              drop_access;

    // Arbitration is only offered while idle and out of reset
    rr_arbiter2 u_rr (
        .req    ({p1_req_valid, p0_req_valid}),
        .last   (last_q),
        .enable ((state_q == IDLE) && !reset),
        .grant  (grant)
    );

    assign p0_req_ready = grant[0];
    assign p1_req_ready = grant[1];
    assign accept       = |grant;

    // Pick the fields of whichever port won so they can be latched on the accept edge
    always_comb begin
        sel_req = '0;
        if (grant[1]) begin
            sel_req.addr    = p1_addr;
            sel_req.wdata   = p1_wdata;
            sel_req.we      = p1_we;
            sel_req.byte_en = p1_byte;
        end else begin
            sel_req.addr    = p0_addr;
            sel_req.wdata   = p0_wdata;
            sel_req.we      = p0_we;
            sel_req.byte_en = p0_byte;
        end
    end

`ifdef DMEM_ADDR_CHECK_EN
    logic addr_oor;
    logic err_q;

    assign addr_oor = ({2'b00, sel_req.addr[DMEM_ADDR_W-1:2]} >= DMEM_ADDR_W'(DEPTH_WORDS));

    // Remember whether the accepted word address lies past the implemented memory
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= addr_oor;
        end
    end

    assign drop_access = err_q;
`else
    logic unused_depth;

    assign unused_depth = ^DEPTH_WORDS;
    assign drop_access  = 1'b0;
`endif

    // State register; reset lands in IDLE so an in-flight access simply vanishes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ACCESS and RESP each last exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning request and its port id; these also hold mem_A/mem_WD between accesses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q <= '0;
            gid_q <= 1'b0;
        end else if (accept) begin
            req_q <= sel_req;
            gid_q <= grant[1];
        end
    end

    // Capture read data during ACCESS and advance the pointer; port 1 "last" so port 0 wins the first tie
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else if (state_q == ACCESS) begin
            last_q  <= gid_q;
            rdata_q <= (req_q.we || drop_access) ? '0 : mem_RD;
        end
    end

    // Memory strobes are combinational on state so an asynchronous reset kills a write at once
    always_comb begin
        mem_A        = req_q.addr;
        mem_WD       = req_q.wdata;
        mem_MW       = 1'b0;
        mem_SB       = 1'b0;
        mem_loadByte = 1'b0;
        if (state_q == ACCESS && !drop_access) begin
            mem_MW       = req_q.we;
            mem_SB       = req_q.we & req_q.byte_en;
            mem_loadByte = ~req_q.we & req_q.byte_en;
        end
    end

    assign busy         = (state_q != IDLE);
    assign p0_rsp_valid = (state_q == RESP) && !gid_q;
    assign p1_rsp_valid = (state_q == RESP) && gid_q;
    assign p0_rdata     = rdata_q;
    assign p1_rdata     = rdata_q;
    assign p0_err       = p0_rsp_valid && drop_access;
    assign p1_err       = p1_rsp_valid && drop_access;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural memoriaDatos.
// Build with DMEM_ADDR_CHECK_EN defined to exercise the address-range check
// (the bench then uses DEPTH_WORDS = 16).
module tb_data_mem_arbiter;

`ifdef DMEM_ADDR_CHECK_EN
    localparam int TB_DEPTH = 16;
`else
    localparam int TB_DEPTH = 16384;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        p0_req_valid = 1'b0, p1_req_valid = 1'b0;
    logic        p0_req_ready, p1_req_ready;
    logic [31:0] p0_addr = '0, p1_addr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_we = 1'b0, p1_we = 1'b0;
    logic        p0_byte = 1'b0, p1_byte = 1'b0;
    logic        p0_rsp_valid, p1_rsp_valid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_err, p1_err;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_MW, mem_SB, mem_loadByte;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Preload channel into both the environment memory and the reference memory
    logic        preload_we = 1'b0;
    logic [13:0] preload_idx = '0;
    logic [31:0] preload_data = '0;

    logic [31:0] env_mem [16384] = '{default: 32'h0};
    logic [31:0] ref_mem [16384] = '{default: 32'h0};

    int grant_log[$];
    int rsp_count = 0;

    always #5 clock = ~clock;

    data_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH_WORDS (TB_DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_we        (p0_we),
        .p0_byte      (p0_byte),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rdata     (p0_rdata),
        .p0_err       (p0_err),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_we        (p1_we),
        .p1_byte      (p1_byte),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rdata     (p1_rdata),
        .p1_err       (p1_err),
        .mem_A        (mem_A),
        .mem_WD       (mem_WD),
        .mem_MW       (mem_MW),
        .mem_SB       (mem_SB),
        .mem_loadByte (mem_loadByte),
        .mem_RD       (mem_RD),
        .busy         (busy)
    );

    // memoriaDatos stand-in: combinational read, byte reads zero-extend the addressed lane
    always_comb begin
        mem_RD = env_mem[mem_A[15:2]];
        if (mem_loadByte) begin
            mem_RD = {24'h0, env_mem[mem_A[15:2]][mem_A[1:0]*8 +: 8]};
        end
    end

    // memoriaDatos stand-in: writes commit on the rising edge while MW is high
    always @(posedge clock) begin
        if (preload_we) begin
            env_mem[preload_idx] <= preload_data;
        end else if (mem_MW) begin
            if (mem_SB) begin
                env_mem[mem_A[15:2]][mem_A[1:0]*8 +: 8] <= mem_WD[7:0];
            end else begin
                env_mem[mem_A[15:2]] <= mem_WD;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] refRead(input logic [31:0] addr, input logic bt);
        logic [31:0] word;
        word = ref_mem[addr[15:2]];
        return bt ? {24'h0, word[addr[1:0]*8 +: 8]} : word;
    endfunction

    // Reference model: transaction-level view of the arbiter, checked every negedge
    initial begin : model
        int          since_accept;
        int          last_g;
        int          g;
        int          m_gid;
        logic [31:0] m_addr, m_wdata, exp_rdata, hold_addr, hold_wdata;
        logic        m_we, m_byte, m_err;
        logic [1:0]  e_ready, e_rsp;
        logic        e_mw, e_sb, e_lb;

        since_accept = -1;
        last_g       = 1;
        m_gid        = 0;
        m_addr       = '0;
        m_wdata      = '0;
        m_we         = 1'b0;
        m_byte       = 1'b0;
        m_err        = 1'b0;
        exp_rdata    = '0;
        hold_addr    = '0;
        hold_wdata   = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                since_accept = -1;
                last_g       = 1;
                hold_addr    = '0;
                hold_wdata   = '0;
                checkOutput("rst_ready", 32'({p1_req_ready, p0_req_ready}), 0);
                checkOutput("rst_rsp", 32'({p1_rsp_valid, p0_rsp_valid}), 0);
                checkOutput("rst_err", 32'({p1_err, p0_err}), 0);
                checkOutput("rst_busy", 32'(busy), 0);
                checkOutput("rst_strobes", 32'({mem_MW, mem_SB, mem_loadByte}), 0);
                checkOutput("rst_memA", mem_A, hold_addr);
                checkOutput("rst_memWD", mem_WD, hold_wdata);
                checkOutput("rst_rdata", p0_rdata, 0);
            end else begin
                if (preload_we) ref_mem[preload_idx] = preload_data;

                g       = -1;
                e_ready = 2'b00;
                e_rsp   = 2'b00;
                e_mw    = 1'b0;
                e_sb    = 1'b0;
                e_lb    = 1'b0;
                if (since_accept < 0) begin
                    if (p0_req_valid && p1_req_valid) g = (last_g == 1) ? 0 : 1;
                    else if (p0_req_valid)            g = 0;
                    else if (p1_req_valid)            g = 1;
                    if (g >= 0) e_ready[g] = 1'b1;
                end else if (since_accept == 1) begin
                    e_mw = m_we & ~m_err;
                    e_sb = m_we & m_byte & ~m_err;
                    e_lb = ~m_we & m_byte & ~m_err;
                end else begin
                    e_rsp[m_gid] = 1'b1;
                end

                checkOutput("ready", 32'({p1_req_ready, p0_req_ready}), 32'(e_ready));
                checkOutput("busy", 32'(busy), 32'(since_accept >= 0));
                checkOutput("strobes", 32'({mem_MW, mem_SB, mem_loadByte}), 32'({e_mw, e_sb, e_lb}));
                checkOutput("memA", mem_A, hold_addr);
                checkOutput("memWD", mem_WD, hold_wdata);
                checkOutput("rsp", 32'({p1_rsp_valid, p0_rsp_valid}), 32'(e_rsp));
                if (e_rsp[0]) begin
                    checkOutput("p0_rdata", p0_rdata, exp_rdata);
                    checkOutput("p0_err", 32'(p0_err), 32'(m_err));
                end
                if (e_rsp[1]) begin
                    checkOutput("p1_rdata", p1_rdata, exp_rdata);
                    checkOutput("p1_err", 32'(p1_err), 32'(m_err));
                end

                if (p0_req_ready && p0_req_valid) grant_log.push_back(0);
                if (p1_req_ready && p1_req_valid) grant_log.push_back(1);
                if (p0_rsp_valid || p1_rsp_valid) rsp_count++;

                if (since_accept < 0 && g >= 0) begin
                    m_gid        = g;
                    m_addr       = (g == 1) ? p1_addr : p0_addr;
                    m_wdata      = (g == 1) ? p1_wdata : p0_wdata;
                    m_we         = (g == 1) ? p1_we : p0_we;
                    m_byte       = (g == 1) ? p1_byte : p0_byte;
`ifdef DMEM_ADDR_CHECK_EN
                    m_err        = (m_addr >> 2) >= 32'(TB_DEPTH);
`else
                    m_err        = 1'b0;
`endif
                    hold_addr    = m_addr;
                    hold_wdata   = m_wdata;
                    since_accept = 1;
                end else if (since_accept == 1) begin
                    last_g    = m_gid;
                    exp_rdata = 32'h0;
                    if (!m_err) begin
                        if (m_we) begin
                            if (m_byte) ref_mem[m_addr[15:2]][m_addr[1:0]*8 +: 8] = m_wdata[7:0];
                            else        ref_mem[m_addr[15:2]] = m_wdata;
                        end else begin
                            exp_rdata = refRead(m_addr, m_byte);
                        end
                    end
                    since_accept = 2;
                end else if (since_accept == 2) begin
                    since_accept = -1;
                end
            end
        end
    end

    task automatic doReset();
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic preload(input logic [13:0] idx, input logic [31:0] data);
        @(posedge clock); #1;
        preload_we   = 1'b1;
        preload_idx  = idx;
        preload_data = data;
        @(posedge clock); #1;
        preload_we   = 1'b0;
    endtask

    // Present one request, wait (bounded) for its handshake, return just after the accept edge
    task automatic applyStimulus(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic we, input logic bt, output int waited);
        @(posedge clock); #1;
        if (port == 0) begin
            p0_addr = addr; p0_wdata = wdata; p0_we = we; p0_byte = bt; p0_req_valid = 1'b1;
        end else begin
            p1_addr = addr; p1_wdata = wdata; p1_we = we; p1_byte = bt; p1_req_valid = 1'b1;
        end
        waited = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if ((port == 0 && p0_req_ready) || (port == 1 && p1_req_ready)) begin
                waited = i;
                break;
            end
        end
        @(posedge clock); #1;
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        if (waited < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: port %0d got no ready within 20 cycles", port);
        end
    endtask

    initial begin : stimulus
        int w;
        int rsp_start;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        checkOutput("rst_busy_literal", 32'(busy), 0);
        checkOutput("rst_memA_literal", mem_A, 0);

        $display("[TB] p0 word read of address 24");
        preload(14'd6, 32'hDEADBEEF);
        applyStimulus(0, 32'd24, 32'h0, 1'b0, 1'b0, w);
        checkOutput("t1_ready_same_cycle", 32'(w), 0);
        @(negedge clock);
        checkOutput("t1_memA", mem_A, 32'd24);
        checkOutput("t1_memMW", 32'(mem_MW), 0);
        @(negedge clock);
        checkOutput("t1_rsp", 32'(p0_rsp_valid), 1);
        checkOutput("t1_rdata", p0_rdata, 32'hDEADBEEF);

        $display("[TB] p1 byte write then byte read at address 72");
        applyStimulus(1, 32'd72, 32'd1114, 1'b1, 1'b1, w);
        @(negedge clock);
        checkOutput("t2_memMW", 32'(mem_MW), 1);
        checkOutput("t2_memSB", 32'(mem_SB), 1);
        checkOutput("t2_memA", mem_A, 32'd72);
        @(negedge clock);
        checkOutput("t2_memMW_one_cycle", 32'(mem_MW), 0);
        checkOutput("t2_rsp", 32'(p1_rsp_valid), 1);
        checkOutput("t2_rdata_write", p1_rdata, 0);
        applyStimulus(1, 32'd72, 32'h0, 1'b0, 1'b1, w);
        @(negedge clock);
        checkOutput("t2_loadByte", 32'(mem_loadByte), 1);
        @(negedge clock);
        checkOutput("t2_byte_rdata", p1_rdata, 32'h5A);

        $display("[TB] both ports requesting for 12 cycles");
        doReset();
        grant_log.delete();
        rsp_start = rsp_count;
        @(posedge clock); #1;
        p0_addr = 32'd24; p0_we = 1'b0; p0_byte = 1'b0; p0_req_valid = 1'b1;
        p1_addr = 32'd72; p1_we = 1'b0; p1_byte = 1'b0; p1_req_valid = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("t3_grant_count", 32'(grant_log.size()), 4);
        if (grant_log.size() == 4) begin
            checkOutput("t3_grant0", 32'(grant_log[0]), 0);
            checkOutput("t3_grant1", 32'(grant_log[1]), 1);
            checkOutput("t3_grant2", 32'(grant_log[2]), 0);
            checkOutput("t3_grant3", 32'(grant_log[3]), 1);
        end
        checkOutput("t3_rsp_count", 32'(rsp_count - rsp_start), 4);

        $display("[TB] reset during the ACCESS of a word write");
        doReset();
        preload(14'(32'hABCD >> 2), 32'h11223344);
        rsp_start = rsp_count;
        applyStimulus(0, 32'hABCD, 32'd20477356, 1'b1, 1'b0, w);
        checkOutput("t4_memMW_before", 32'(mem_MW), 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("t4_memMW_dropped", 32'(mem_MW), 0);
        checkOutput("t4_busy_dropped", 32'(busy), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("t4_word_unchanged", env_mem[14'(32'hABCD >> 2)], 32'h11223344);
        checkOutput("t4_no_rsp", 32'(rsp_count - rsp_start), 0);
        applyStimulus(0, 32'h10, 32'h0, 1'b0, 1'b0, w);
        checkOutput("t4_ready_after_reset", 32'(w), 0);
        repeat (2) @(negedge clock);

`ifdef DMEM_ADDR_CHECK_EN
        $display("[TB] address check: out-of-range write and in-range read");
        applyStimulus(0, 32'h40, 32'h12345678, 1'b1, 1'b0, w);
        @(negedge clock);
        checkOutput("t5_memMW_blocked", 32'(mem_MW), 0);
        @(negedge clock);
        checkOutput("t5_rsp", 32'(p0_rsp_valid), 1);
        checkOutput("t5_err", 32'(p0_err), 1);
        checkOutput("t5_rdata", p0_rdata, 0);
        preload(14'd15, 32'hCAFEF00D);
        applyStimulus(0, 32'h3C, 32'h0, 1'b0, 1'b0, w);
        repeat (2) @(negedge clock);
        checkOutput("t5_inrange_rsp", 32'(p0_rsp_valid), 1);
        checkOutput("t5_inrange_err", 32'(p0_err), 0);
        checkOutput("t5_inrange_rdata", p0_rdata, 32'hCAFEF00D);
`endif

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
